// File: rtl/peak_event_tracker_pkg.sv
// Shared types and constants for the peak event tracker.
// The record struct widths here define the record width; the tracker's
// IBITS/EBITS parameters default to these values and must match them.
package peak_tracker_pkg;

  localparam int DROP_BITS = 8;
  localparam int REC_IBITS = 18;
  localparam int REC_EBITS = 16;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  typedef struct packed {
    logic [REC_IBITS-1:0] interval;
    logic [REC_EBITS-1:0] index;
  } evt_rec_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_BITS-1:0] sat_inc_drop(input logic [DROP_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/peak_event_tracker_if.sv
// Valid/ready event record channel between the peak tracker and its monitor.
interface peak_event_tracker_if
  import peak_tracker_pkg::*;
#(
  parameter int IBITS = REC_IBITS,
  parameter int EBITS = REC_EBITS
);

  logic             evt_valid;
  logic             evt_ready;
  logic [IBITS-1:0] evt_interval;
  logic [EBITS-1:0] evt_index;

  modport master (output evt_valid, output evt_interval, output evt_index, input evt_ready);
  modport slave  (input evt_valid, input evt_interval, input evt_index, output evt_ready);

endinterface

// File: rtl/peak_event_tracker_queue.sv
// Two-entry record FIFO. Entry 0 is always the head; a pop shifts entry 1
// down. A push into a full queue is accepted only if a pop happens in the
// same cycle, otherwise it is discarded and flagged on push_drop.
module peak_evt_queue
  import peak_tracker_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     push,
  input  evt_rec_t push_rec,
  output logic     out_valid,
  input  logic     out_ready,
  output evt_rec_t head_rec,
  output logic     push_drop
);

  evt_rec_t   ent0_q, ent0_d;
  evt_rec_t   ent1_q, ent1_d;
  logic [1:0] count_q, count_d;
  logic       pop;

  assign out_valid = (count_q != 2'd0);
  assign head_rec  = ent0_q;
  assign pop       = out_valid & out_ready;
  assign push_drop = push & (count_q == 2'd2) & ~pop;

  // Next queue contents from the push/pop combination
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (clr) begin
      ent0_d  = '0;
      ent1_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = push_rec;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_rec;
          end
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d  = push_rec;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            ent1_d  = push_rec;
            count_d = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/peak_event_tracker.sv
// Peak event tracker: edge-detects sig_in, measures peak-to-peak interval,
// numbers events, checks pulse width and queues records to the monitor.
// Optional period check enabled by defining PEAK_TRACKER_PERIOD_CHECK_EN.
module peak_event_tracker
  import peak_tracker_pkg::*;
#(
  parameter int IBITS      = REC_IBITS,
  parameter int EBITS      = REC_EBITS,
  parameter int MAX_HIGH   = 2,
  parameter int EXP_PERIOD = 100002,
  parameter int TOL        = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 clr,
  peak_event_tracker_if.master evt,
  output logic                 width_err,
  output logic [DROP_BITS-1:0] drop_cnt,
  output logic                 period_err
);

  localparam int               HBITS    = $clog2(MAX_HIGH + 2);
  localparam logic [HBITS-1:0] HIGH_SAT = HBITS'(MAX_HIGH + 1);

  state_t               state_q, state_d;
  logic                 sig_q;
  logic [IBITS-1:0]     cnt_q, cnt_d;
  logic [EBITS-1:0]     event_cnt_q, event_cnt_d;
  logic [HBITS-1:0]     high_run_q, high_run_d;
  logic                 width_err_q, width_err_d;
  logic [DROP_BITS-1:0] drop_cnt_q, drop_cnt_d;
  logic                 period_err_q, period_err_d;
  logic                 rise;
  logic                 push;
  logic                 push_drop;
  logic                 period_bad;
  evt_rec_t             push_rec;
  evt_rec_t             head_rec;

  assign rise = sig_in & ~sig_q;

  // Interval FSM: first peak arms the counter, later peaks emit records
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    event_cnt_d = event_cnt_q;
    push        = 1'b0;
    push_rec    = '0;
    if (clr) begin
      state_d     = WAIT_FIRST;
      cnt_d       = '0;
      event_cnt_d = '0;
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          cnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = IBITS'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            push              = 1'b1;
            push_rec.interval = cnt_q;
            push_rec.index    = event_cnt_q + 1'b1;
            event_cnt_d       = event_cnt_q + 1'b1;
            cnt_d             = IBITS'(1);
          end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

`ifdef PEAK_TRACKER_PERIOD_CHECK_EN
  localparam logic [IBITS-1:0] EXP_V = IBITS'(EXP_PERIOD);
  localparam logic [IBITS-1:0] TOL_V = IBITS'(TOL);
  logic [IBITS-1:0] period_diff;

  // Absolute deviation of the measured interval from the nominal period
  always_comb begin
    period_diff = (push_rec.interval > EXP_V) ? (push_rec.interval - EXP_V)
                                              : (EXP_V - push_rec.interval);
    period_bad  = push & ((&push_rec.interval) | (period_diff > TOL_V));
  end
`else
  assign period_bad = 1'b0;
`endif

  // Width check, drop counter and sticky error flags
  always_comb begin
    high_run_d   = '0;
    width_err_d  = width_err_q;
    drop_cnt_d   = drop_cnt_q;
    period_err_d = period_err_q;
    if (sig_in) begin
      high_run_d = (high_run_q == HIGH_SAT) ? high_run_q : high_run_q + 1'b1;
    end
    if (clr) begin
      width_err_d  = 1'b0;
      drop_cnt_d   = '0;
      period_err_d = 1'b0;
    end else begin
      if (high_run_d == HIGH_SAT) width_err_d = 1'b1;
      if (push_drop) drop_cnt_d = sat_inc_drop(drop_cnt_q);
      if (period_bad) period_err_d = 1'b1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_FIRST;
      sig_q        <= 1'b0;
      cnt_q        <= '0;
      event_cnt_q  <= '0;
      high_run_q   <= '0;
      width_err_q  <= 1'b0;
      drop_cnt_q   <= '0;
      period_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_in;
      cnt_q        <= cnt_d;
      event_cnt_q  <= event_cnt_d;
      high_run_q   <= high_run_d;
      width_err_q  <= width_err_d;
      drop_cnt_q   <= drop_cnt_d;
      period_err_q <= period_err_d;
    end
  end

  peak_evt_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_rec  (push_rec),
    .out_valid (evt.evt_valid),
    .out_ready (evt.evt_ready),
    .head_rec  (head_rec),
    .push_drop (push_drop)
  );

  assign evt.evt_interval = head_rec.interval;
  assign evt.evt_index    = head_rec.index;
  assign width_err        = width_err_q;
  assign drop_cnt         = drop_cnt_q;
  assign period_err       = period_err_q;

endmodule

// File: doc/peak_event_tracker.md
Name: peak_event_tracker

Overview:
- Downstream consumer of the `sig` peak pulse from the load/store volume ramp.
- Rising-edge detects `sig`, measures the cycle interval between consecutive peaks, and counts events.
- Checks pulse width against a limit.
- Pushes per-event records (interval, event index) through a 2-entry output queue with valid/ready handshake to the monitoring logic.

Parameters:
- IBITS, 18, interval counter width (covers one full ramp period at default volume).
- EBITS, 16, event counter width.
- MAX_HIGH, 2, maximum legal consecutive cycles of `sig_in` high.
- EXP_PERIOD, 100002, nominal peak-to-peak interval in cycles (used only with the optional feature).
- TOL, 4, allowed absolute deviation from EXP_PERIOD.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- sig_in  in  1  peak pulse from upstream.
- clr  in  1  synchronous clear of counters, flags and queue; state returns to WAIT_FIRST.
- evt_valid  out  1  queue head valid.
- evt_ready  in  1  consumer accepts head.
- evt_interval  out  IBITS  cycles since previous peak, saturated.
- evt_index  out  EBITS  event number, first measured interval = 1.
- width_err  out  1  sticky: `sig_in` high longer than MAX_HIGH.
- drop_cnt  out  8  events lost to a full queue, saturating at 255.
- period_err  out  1  sticky period mismatch (optional feature only; tied 0 otherwise).

Behaviour:
- Interface:
  - One clock `clk`.
  - `rst` is asynchronous and active-high; all registers clear immediately on assertion.
  - On reset: evt_valid=0, evt_interval=0, evt_index=0, width_err=0, drop_cnt=0, period_err=0, queue empty, state=WAIT_FIRST.
- Edge detect:
  - `sig_in` is registered once (sig_q).
  - rise = sig_in & ~sig_q.
  - The upstream is synchronous, so no extra synchroniser is used.
- FSM:
  - WAIT_FIRST: interval counter held at 0. On rise -> MEASURE with counter=1. No record is produced for the first peak.
  - MEASURE: counter increments every cycle, saturating at all-ones.
  - On rise in MEASURE, a record {interval=counter value, index=event_cnt+1} is produced, event_cnt increments (wraps modulo 2^EBITS), and the counter reloads to 1 in the same cycle.
- Latency: evt_valid asserts the cycle after the rise-detect cycle (record registered into the queue).
- Queue:
  - 2 entries. Push on record; pop when evt_valid & evt_ready.
  - Simultaneous push and pop when full is accepted with no drop.
  - Push when full and no pop: record discarded, drop_cnt+1 (saturating).
  - Outputs reflect the head entry and are stable while evt_valid=1 and evt_ready=0.
- Width check:
  - high_run counts consecutive high cycles of `sig_in` and saturates at MAX_HIGH+1.
  - width_err sets when high_run reaches MAX_HIGH+1.
  - width_err stays set until clr or rst.
- clr:
  - Has priority over a same-cycle rise; that rise is ignored.
  - Clears the queue, event_cnt, drop_cnt, width_err, period_err and interval counter.
- A high level persisting across clr does not generate a rise afterwards, because sig_q keeps tracking.

Optional Feature:
- Macro: PEAK_TRACKER_PERIOD_CHECK_EN.
- Defined: on every produced record, if |interval − EXP_PERIOD| > TOL, period_err sets (sticky until clr/rst). A saturated interval always mismatches.
- Undefined: no comparator is built and period_err is driven constant 0.

Decomposition:
- Package peak_tracker_pkg holds:
  - the state enum typedef (WAIT_FIRST, MEASURE);
  - a record struct typedef {interval, index};
  - the DROP_BITS=8 constant.
- Sub-module peak_evt_queue: 2-entry valid/ready FIFO of the record struct, reporting full/push_drop.

Test Plan:
- Reset and first peak: rst pulse, then sig_in high 2 cycles at t=10 -> no evt_valid, state MEASURE, all outputs 0.
- Interval measurement (EXP_PERIOD=20, TOL=1): rises at t=10 and t=30, evt_ready=1 -> evt_valid at t=31 with evt_interval=20, evt_index=1.
- Backpressure: evt_ready=0, three intervals of 8 cycles -> queue holds indices 1,2; third is dropped with drop_cnt=1. Raising evt_ready pops 1 then 2 on consecutive cycles.
- Width error (MAX_HIGH=2): sig_in high 2 cycles -> width_err=0; later high 3 cycles -> width_err=1 on the 3rd high cycle, held after the pulse ends.
- clr mid-run: clr coinciding with a rise and a full queue -> evt_valid=0, drop_cnt=0, next rise treated as first peak (no record).
- Feature on (EXP_PERIOD=20, TOL=1): intervals 20, 21, 23 -> period_err stays 0, 0, then sets on the 23 record; feature off -> period_err stays 0 throughout.
